// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO.
// Shift-add multiply and restoring divide on magnitudes; signs fixed up in FIX.
module ex_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] result
);

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  localparam logic [DATA_W-1:0]   ONE  = DATA_W'(1);
  localparam logic [2*DATA_W-1:0] ONE2 = (2*DATA_W)'(1);
  localparam logic [CNT_W-1:0]    LAST = CNT_W'(DATA_W-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mag_b;
  logic                q_neg, r_neg, is_div, dz;

  logic op_mul, op_div, op_sgn, op_mthi, op_mtlo;
  logic go, b_zero, last;
  logic [DATA_W-1:0]   mag_a_in, mag_b_in;
  logic [DATA_W:0]     mul_sum, div_trial;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_sgn  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    unique case (1'b1)
      (alu_control == OP_MULT):  begin op_mul = 1'b1; op_sgn = 1'b1; end
      (alu_control == OP_MULTU): op_mul = 1'b1;
      (alu_control == OP_DIV):   begin op_div = 1'b1; op_sgn = 1'b1; end
      (alu_control == OP_DIVU):  op_div = 1'b1;
      (alu_control == OP_MTHI):  op_mthi = 1'b1;
      (alu_control == OP_MTLO):  op_mtlo = 1'b1;
      default: ;
    endcase
  end

  assign go     = start && !flush && (state == S_IDLE);
  assign b_zero = (operand_b == '0);
  assign last   = (cnt == LAST);
  assign busy   = (state != S_IDLE);

  assign mag_a_in = (op_sgn && operand_a[DATA_W-1]) ? ~operand_a + ONE
                                                    : operand_a;
  assign mag_b_in = (op_sgn && operand_b[DATA_W-1]) ? ~operand_b + ONE
                                                    : operand_b;

  assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]}
                   + {1'b0, (acc[0] ? mag_b : '0)};
  assign div_trial = acc[2*DATA_W-1:DATA_W-1] - {1'b0, mag_b};

  assign prod   = q_neg ? ~acc + ONE2 : acc;
  assign quo    = acc[DATA_W-1:0];
  assign rem    = acc[2*DATA_W-1:DATA_W];
  assign fix_lo = is_div ? (q_neg ? ~quo + ONE : quo) : prod[DATA_W-1:0];
  assign fix_hi = is_div ? (r_neg ? ~rem + ONE : rem)
                         : prod[2*DATA_W-1:DATA_W];

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (go && op_mul) state_nx = S_MUL;
        if (go && op_div) state_nx = b_zero ? S_FIX : S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush)     state_nx = S_IDLE;
        else if (last) state_nx = S_FIX;
      end
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      acc         <= '0;
      mag_b       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        S_IDLE: if (go) begin
          if (op_mthi) hi <= operand_a;
          if (op_mtlo) lo <= operand_a;
          if (op_mul || op_div) begin
            cnt    <= '0;
            mag_b  <= mag_b_in;
            is_div <= op_div;
            dz     <= op_div && b_zero;
            r_neg  <= op_sgn && operand_a[DATA_W-1];
            // Zero divisor: preload so the normal fixup yields hi=a, lo=all-ones
            q_neg  <= op_sgn && (operand_a[DATA_W-1] ^ operand_b[DATA_W-1])
                      && !(op_div && b_zero);
            acc    <= (op_div && b_zero) ? {mag_a_in, {DATA_W{1'b1}}}
                                         : {{DATA_W{1'b0}}, mag_a_in};
          end
        end
        S_MUL: begin
          if (flush) cnt <= '0;
          else begin
            acc <= {mul_sum, acc[DATA_W-1:1]};
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (flush) cnt <= '0;
          else begin
            if (!div_trial[DATA_W])
              acc <= {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            else
              acc <= {acc[2*DATA_W-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          cnt <= '0;
          if (!flush) begin
            hi          <= fix_hi;
            lo          <= fix_lo;
            done        <= 1'b1;
            div_by_zero <= dz;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (alu_control == OP_MFHI)      result = hi;
    else if (alu_control == OP_MFLO) result = lo;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit.
// Expected HI/LO come from plain 64-bit arithmetic on the operands.
module tb_ex_muldiv_unit;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  alu_control;
  logic [31:0] operand_a, operand_b;
  logic        flush;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo, result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  ex_muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_op(input logic [5:0] code, input logic [31:0] a, b,
                        output logic [31:0] h, output logic [31:0] l,
                        output logic z);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (code)
      OP_MULT: begin
        p = 64'(sa * sb);
        h = p[63:32];
        l = p[31:0];
      end
      OP_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 0) begin
          h = a;
          l = 32'hFFFF_FFFF;
          z = 1'b1;
        end else if (code == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Caller is at a negedge; drives one start cycle and returns one negedge later
  task automatic issue(input logic [5:0] code, input logic [31:0] a, b);
    start       = 1'b1;
    alu_control = code;
    operand_a   = a;
    operand_b   = b;
    @(negedge clk);
    start       = 1'b0;
    alu_control = 6'b000000;
  endtask

  task automatic run_op(input logic [5:0] code, input logic [31:0] a, b,
                        input bit tail);
    logic [31:0] eh, el;
    logic        ez;
    int          cyc;
    ref_op(code, a, b, eh, el, ez);
    issue(code, a, b);
    cyc = 0;
    for (int k = 0; k < 45 && !done; k++) begin
      if (busy) cyc++;
      @(negedge clk);
    end
    chk("done_seen", done, 1);
    chk("busy_cycles", cyc, ez ? 1 : 33);
    chk("busy_at_done", busy, 0);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("div_by_zero", div_by_zero, ez);
    model_hi = eh;
    model_lo = el;
    if (tail) begin
      @(negedge clk);
      chk("done_pulse_end", done, 0);
      chk("dz_pulse_end", div_by_zero, 0);
    end
  endtask

  task automatic check_mf();
    alu_control = OP_MFHI;
    #1 chk("mfhi", result, model_hi);
    alu_control = OP_MFLO;
    #1 chk("mflo", result, model_lo);
    alu_control = 6'b100000;
    #1 chk("result_other", result, 0);
    alu_control = 6'b000000;
    @(negedge clk);
  endtask

  initial begin
    int          seen;
    logic [5:0]  codes [6];
    logic [5:0]  c;
    logic [31:0] ra, rb;
    codes = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    alu_control = '0; operand_a = '0; operand_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    alu_control = OP_MFHI;
    #1 chk("mfhi_multu", result, 32'hFFFF_FFFE);
    // New start in the same cycle as the done pulse
    run_op(OP_DIVU, 32'd100, 32'd7, 1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, 1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd0, 1);

    // MTLO, then MULT aborted by flush; start during busy ignored
    issue(OP_MTLO, 32'hA5A5_A5A5, 32'h0);
    model_lo = 32'hA5A5_A5A5;
    chk("mtlo", lo, model_lo);
    issue(OP_MULT, 32'd1234, 32'd5678);
    repeat (4) @(negedge clk);
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    chk("busy_ignore_start", busy, 1);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("flush_no_done", seen, 0);
    chk("flush_lo", lo, 32'hA5A5_A5A5);
    chk("flush_hi", hi, model_hi);

    // flush and start together in IDLE: nothing accepted
    flush = 1'b1;
    issue(OP_MULT, 32'd3, 32'd3);
    chk("flush_start_busy", busy, 0);
    issue(OP_MTHI, 32'h1111_1111, 32'h0);
    flush = 1'b0;
    chk("flush_start_hi", hi, model_hi);

    // Reset partway through a DIV
    issue(OP_DIV, 32'h7654_3210, 32'd3);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_MULT, 32'd6, 32'd7, 1);

    for (int i = 0; i < 24; i++) begin
      c  = codes[$urandom_range(0, 5)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      if (c == OP_MTHI || c == OP_MTLO) begin
        issue(c, ra, rb);
        if (c == OP_MTHI) model_hi = ra;
        else              model_lo = ra;
        chk("mt_hi", hi, model_hi);
        chk("mt_lo", lo, model_lo);
        chk("mt_busy", busy, 0);
      end else begin
        run_op(c, ra, rb, 1);
      end
      check_mf();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Multi-cycle multiply/divide execution unit in the EX stage. It consumes the 6-bit alu_control code produced by the ALU control decoder, acting as the receiving end of that code for the HI/LO function codes. It executes MULT/MULTU/DIV/DIVU iteratively, owns the HI/LO registers, and serves MTHI/MTLO/MFHI/MFLO. It asserts busy so the hazard unit can stall the pipeline.

Parameters:
DATA_W, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; must hold DATA_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  instruction in EX carries a valid alu_control code this cycle
alu_control  input  6  function code from the ALU control decoder
operand_a  input  DATA_W  rs value (dividend / multiplicand / MTHI-MTLO source)
operand_b  input  DATA_W  rt value (divisor / multiplier)
flush  input  1  synchronous abort of the in-flight operation
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when HI/LO are written by MULT*/DIV*
div_by_zero  output  1  high together with done when a DIV/DIVU had operand_b==0
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register
result  output  DATA_W  combinational: hi for MFHI (010000), lo for MFLO (010010), else 0

Behaviour:
- Recognised codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. All other codes are ignored: no state change, result=0.
- Reset (rst_n low, asynchronous): state=IDLE, hi=lo=0, counter=0, busy=0, done=0, div_by_zero=0.
- FSM states: IDLE, MUL, DIV, FIX. busy = (state != IDLE). done and div_by_zero are registered.
- IDLE, start with MULT*/DIV* at edge E0:
  - latch the magnitudes of the operands. Signed ops take the two's-complement absolute value. Unsigned ops use the operands unchanged.
  - latch the result-sign flags: quotient/product sign = a[31]^b[31]; remainder sign = a[31].
  - counter=0, go to MUL or DIV.
- MUL: one shift-add step per cycle on a 2*DATA_W accumulator. The state runs DATA_W cycles (edges E1..E32), then goes to FIX.
- DIV: one restoring shift-subtract step per cycle over DATA_W cycles (E1..E32), then goes to FIX.
- FIX (edge E33):
  - apply the sign fixup and write hi/lo. Multiply: {hi,lo} = product. Divide: lo = quotient, hi = remainder.
  - done=1 for exactly the following cycle; return to IDLE.
  - busy is therefore high for 33 cycles, and hi/lo are valid in the cycle done is high.
- Divide by zero (operand_b==0 at start, DIV or DIVU): skip iteration and go to FIX directly.
  - hi=operand_a, lo=32'hFFFFFFFF, done=1 and div_by_zero=1 after edge E1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural magnitude-algorithm result and is not flagged.
- MTHI/MTLO with start in IDLE: hi (or lo) = operand_a at the same edge. No busy, no done.
- MFHI/MFLO: result reflects the current hi/lo. The consumer stalls while busy, so a read never observes a partial value.
- start while busy: ignored for all codes, including MTHI/MTLO. The operation in flight continues unaffected.
- flush while busy: return to IDLE at the next edge. hi/lo unchanged, no done, counter cleared.
- flush and start asserted in the same IDLE cycle: flush wins and nothing is accepted.
- done pulse and a new start in the same cycle: the new start is accepted, because the state is IDLE.
- Reset mid-operation: immediate return to the reset values; no partial result is written.
- All arithmetic is modulo 2^DATA_W per half. Negation is two's complement: ~x+1.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> busy 33 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MFHI -> result=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> done and div_by_zero one cycle after start, hi=0x1234, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- MTLO 0xA5A5A5A5, then MULT started. Assert flush at cycle 10 -> busy drops, no done, lo still 0xA5A5A5A5. A start issued during busy is ignored.
- rst_n low at cycle 20 of a DIV -> hi=lo=0, busy=0 immediately. After release, a new MULT 6*7 gives lo=42, hi=0.
